// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - opcode constants, instruction field positions and FSM state encoding
//
// Shared by alu_issue_ctrl and its sub-module. No ports.

package alu_issue_ctrl_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_COM = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;

  // Instruction field positions: opcode[15:12], rd[11:8], rs1[7:4], rs2[3:0]
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;
  localparam int FLD_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MWAIT = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  // Opcodes 8..15 are illegal: only the low eight encodings are defined.
  function automatic logic is_legal(input logic [3:0] opc);
    return (opc[3] == 1'b0);
  endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// rtl/alu_lat_counter.sv - 4-bit loadable down-counter with zero flag for the MUL wait countdown
//
// Ports:
//   clk, rst       clock / asynchronous active-high reset
//   i_load         load i_load_val (has priority over i_en)
//   i_en           decrement by one; holds at zero
//   i_load_val[3:0] value to load
//   o_zero         count is zero

module alu_lat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [3:0] i_load_val,
  output logic       o_zero
);

  logic [3:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - sequenced issue controller: accept, EXEC/MWAIT for MUL latency, single-cycle WB pulse
//
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcodes trap in EXEC instead of running as NOPs).
//
// Ports:
//   clk, rst           clock / asynchronous active-high reset
//   inst_valid, inst   instruction handshake input (opcode, rd, rs1, rs2)
//   inst_ready         block accepts an instruction this cycle (IDLE or WB)
//   rs1_addr, rs2_addr register read addresses from the held instruction
//   aluop              opcode[2:0] of the held instruction
//   wen, waddr         single-cycle register write pulse and destination
//   busy               state is not IDLE
//   illegal            single-cycle trap pulse in EXEC (0 unless ILLEGAL_TRAP_EN)

module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int RA_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  input  logic [15:0]     inst,
  output logic            inst_ready,
  output logic [RA_W-1:0] rs1_addr,
  output logic [RA_W-1:0] rs2_addr,
  output logic [2:0]      aluop,
  output logic            wen,
  output logic [RA_W-1:0] waddr,
  output logic            busy,
  output logic            illegal
);

  state_t      r_state;
  logic [15:0] r_ir;
  logic        r_inst_ready;
  logic        r_wen;
  logic        r_illegal;

  state_t      w_next;
  logic        w_accept;
  logic        w_cnt_load;
  logic        w_cnt_en;
  logic        w_cnt_zero;
  logic [3:0]  w_ir_opc;
  logic [3:0]  w_ir_rd;
  logic [3:0]  w_in_opc;

  assign w_ir_opc = r_ir[OPC_LSB +: FLD_W];
  assign w_ir_rd  = r_ir[RD_LSB  +: FLD_W];
  assign w_in_opc = inst[OPC_LSB +: FLD_W];

  // r_inst_ready is itself registered, so it stays low until the first edge after reset.
  assign w_accept = inst_valid && r_inst_ready;

  always_comb begin
    w_next     = r_state;
    w_cnt_load = 1'b0;
    w_cnt_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (w_ir_opc == OP_MUL) begin
          // EXEC is the first of MUL_LAT cycles; MWAIT runs counts MUL_LAT-2 .. 0.
          w_cnt_load = 1'b1;
          w_next     = ST_MWAIT;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          w_next = is_legal(w_ir_opc) ? ST_WB : ST_IDLE;
`else
          w_next = ST_WB;
`endif
        end
      end
      ST_MWAIT: begin
        if (w_cnt_zero) begin
          w_next = ST_WB;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      ST_WB: begin
        w_next = w_accept ? ST_EXEC : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs are registered against the next state so none depend combinationally on inst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ir         <= 16'd0;
      r_inst_ready <= 1'b0;
      r_wen        <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_state      <= w_next;
      if (w_accept) r_ir <= inst;
      r_inst_ready <= (w_next == ST_IDLE) || (w_next == ST_WB);
      // Entering WB: write unless rd is r0 or the op was an illegal NOP.
      r_wen        <= (w_next == ST_WB) && (r_state != ST_WB) &&
                      (w_ir_rd != 4'd0) && is_legal(w_ir_opc);
`ifdef ILLEGAL_TRAP_EN
      r_illegal    <= w_accept && !is_legal(w_in_opc);
`else
      r_illegal    <= 1'b0;
`endif
    end
  end

  alu_lat_counter u_lat_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_en       (w_cnt_en),
    .i_load_val (4'(MUL_LAT - 2)),
    .o_zero     (w_cnt_zero)
  );

  assign inst_ready = r_inst_ready;
  assign rs1_addr   = RA_W'(r_ir[RS1_LSB +: FLD_W]);
  assign rs2_addr   = RA_W'(r_ir[RS2_LSB +: FLD_W]);
  assign aluop      = w_ir_opc[2:0];
  assign wen        = r_wen;
  assign waddr      = RA_W'(w_ir_rd);
  assign busy       = (r_state != ST_IDLE);
`ifdef ILLEGAL_TRAP_EN
  assign illegal    = r_illegal;
`else
  assign illegal    = 1'b0;
  logic w_unused;
  assign w_unused   = r_illegal ^ (^w_in_opc);
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl

module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        inst_valid;
  logic [15:0] inst;
  logic        inst_ready;
  logic [3:0]  rs1_addr;
  logic [3:0]  rs2_addr;
  logic [2:0]  aluop;
  logic        wen;
  logic [3:0]  waddr;
  logic        busy;
  logic        illegal;

  int n_chk = 0;
  int n_err = 0;

  alu_issue_ctrl #(.MUL_LAT(4), .RA_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_ready (inst_ready),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .aluop      (aluop),
    .wen        (wen),
    .waddr      (waddr),
    .busy       (busy),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] opc, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2);
    return {opc, rd, rs1, rs2};
  endfunction

  initial begin
    rst        = 1'b1;
    inst_valid = 1'b0;
    inst       = 16'd0;

    // Reset state
    #3;
    chk("rst_ready", inst_ready, 0);
    chk("rst_busy",  busy,       0);
    chk("rst_wen",   wen,        0);
    chk("rst_ill",   illegal,    0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ready_pre_edge", inst_ready, 0);
    @(negedge clk);
    chk("rel_ready_post_edge", inst_ready, 1);
    chk("rel_busy", busy, 0);

    // ADD rd=3 rs1=1 rs2=2
    inst = mk(4'd0, 4'd3, 4'd1, 4'd2); inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    chk("add_exec_busy",  busy,       1);
    chk("add_exec_ready", inst_ready, 0);
    chk("add_exec_aluop", aluop,      0);
    chk("add_exec_rs1",   rs1_addr,   1);
    chk("add_exec_rs2",   rs2_addr,   2);
    chk("add_exec_wen",   wen,        0);
    @(negedge clk);
    chk("add_wb_wen",   wen,        1);
    chk("add_wb_waddr", waddr,      3);
    chk("add_wb_ready", inst_ready, 1);
    chk("add_wb_busy",  busy,       1);
    @(negedge clk);
    chk("add_idle_wen",  wen,  0);
    chk("add_idle_busy", busy, 0);

    // Back-to-back SUB rd=4 then XOR rd=6
    inst = mk(4'd1, 4'd4, 4'd5, 4'd6); inst_valid = 1'b1;
    @(negedge clk);
    chk("sub_exec_aluop", aluop, 1);
    chk("sub_exec_wen",   wen,   0);
    inst = mk(4'd3, 4'd6, 4'd7, 4'd8);
    @(negedge clk);
    chk("sub_wb_wen",   wen,        1);
    chk("sub_wb_waddr", waddr,      4);
    chk("sub_wb_ready", inst_ready, 1);
    @(negedge clk);
    inst_valid = 1'b0;
    chk("xor_exec_wen",   wen,   0);
    chk("xor_exec_aluop", aluop, 3);
    chk("xor_exec_rs1",   rs1_addr, 7);
    chk("xor_exec_busy",  busy,  1);
    @(negedge clk);
    chk("xor_wb_wen",   wen,   1);
    chk("xor_wb_waddr", waddr, 6);
    @(negedge clk);
    chk("xor_idle_busy", busy, 0);
    chk("xor_idle_wen",  wen,  0);

    // MUL rd=5, latency 4
    inst = mk(4'd7, 4'd5, 4'd8, 4'd9); inst_valid = 1'b1;
    @(negedge clk);
    inst = mk(4'd0, 4'd1, 4'd1, 4'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mul_wait%0d_ready", i), inst_ready, 0);
      chk($sformatf("mul_wait%0d_wen",   i), wen,        0);
      chk($sformatf("mul_wait%0d_aluop", i), aluop,      7);
      @(negedge clk);
    end
    inst_valid = 1'b0;
    chk("mul_wb_wen",   wen,   1);
    chk("mul_wb_waddr", waddr, 5);
    chk("mul_wb_aluop", aluop, 7);
    @(negedge clk);
    chk("mul_idle_wen",  wen,  0);
    chk("mul_idle_busy", busy, 0);

    // SLL rd=0: WB visited, no write
    inst = mk(4'd4, 4'd0, 4'd1, 4'd1); inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    chk("sll_exec_busy", busy, 1);
    @(negedge clk);
    chk("sll_wb_wen",   wen,        0);
    chk("sll_wb_busy",  busy,       1);
    chk("sll_wb_ready", inst_ready, 1);
    @(negedge clk);
    chk("sll_idle_busy", busy, 0);

    // Asynchronous reset mid-MWAIT
    inst = mk(4'd7, 4'd7, 4'd2, 4'd3); inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    @(negedge clk);
    chk("rmul_mwait_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",  busy,       0);
    chk("arst_ready", inst_ready, 0);
    chk("arst_wen",   wen,        0);
    chk("arst_aluop", aluop,      0);
    chk("arst_rs1",   rs1_addr,   0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_rel_ready_pre", inst_ready, 0);
    @(negedge clk);
    chk("arst_rel_ready", inst_ready, 1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("arst_nowen%0d", i), wen, 0);
      chk($sformatf("arst_idle%0d", i), busy, 0);
      @(negedge clk);
    end

    // Illegal opcode 4'hA
    inst = mk(4'hA, 4'd2, 4'd1, 4'd1); inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    chk("ill_exec_busy", busy, 1);
    chk("ill_exec_wen",  wen,  0);
`ifdef ILLEGAL_TRAP_EN
    chk("ill_exec_illegal", illegal, 1);
    @(negedge clk);
    chk("ill_next_busy",    busy,       0);
    chk("ill_next_illegal", illegal,    0);
    chk("ill_next_wen",     wen,        0);
    chk("ill_next_ready",   inst_ready, 1);
`else
    chk("ill_exec_illegal", illegal, 0);
    @(negedge clk);
    chk("ill_wb_busy",    busy,       1);
    chk("ill_wb_wen",     wen,        0);
    chk("ill_wb_illegal", illegal,    0);
    chk("ill_wb_ready",   inst_ready, 1);
    @(negedge clk);
    chk("ill_idle_busy", busy, 0);
`endif

    // Recovery: AND rd=9 after the illegal op
    @(negedge clk);
    inst = mk(4'd2, 4'd9, 4'd4, 4'd5); inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    chk("and_exec_aluop", aluop, 2);
    @(negedge clk);
    chk("and_wb_wen",   wen,   1);
    chk("and_wb_waddr", waddr, 9);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
